// File: rtl/blend_th_ctrl.sv
// Blend-threshold comparator sequencer: double-buffered thresholds, pixel stream framing, registered result stream.
// Optional per-frame histogram counters are enabled with the BLEND_STATS_EN macro.
//
// state | meaning
// IDLE  | waiting for a start-of-frame pixel; non-sof pixels are dropped
// RUN   | inside a frame, tracking x/y position
// ERR   | one-cycle malformed-frame recovery, input stalled
module blend_th_ctrl #(
    parameter int         IMG_W   = 640,
    parameter int         IMG_H   = 480,
    parameter logic [7:0] TH0_RST = 8'd10,
    parameter logic [7:0] TH1_RST = 8'd240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [7:0]  cfg_th0,
    input  logic [7:0]  cfg_th1,
    output logic        cfg_err,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_sof,
    input  logic        in_eol,
    output logic [7:0]  cmp_a,
    output logic [7:0]  cmp_th0,
    output logic [7:0]  cmp_th1,
    input  logic [7:0]  cmp_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eol,
`ifdef BLEND_STATS_EN
    output logic [23:0] stat_lo,
    output logic [23:0] stat_mid,
    output logic [23:0] stat_hi,
    output logic        stat_vld,
`endif
    output logic        frm_err,
    output logic        busy
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_AFTER_SOF = (IMG_W > 1) ? XW'(1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ERR} state_t;

    state_t        state, state_nxt;
    logic [XW-1:0] x_cnt, x_nxt, pos_x;
    logic [YW-1:0] y_cnt, y_nxt, pos_y;
    logic          restart, restart_nxt;
    logic [7:0]    sh_th0, sh_th1, act_th0, act_th1;
    logic [7:0]    eff_th0, eff_th1;
    logic          xfer, sof_xfer, th_ok, take_th;
    logic          fwd, step, err_set, eof_hit;

    assign in_ready = (state != S_ERR) && (!out_valid || out_ready);
    assign xfer     = in_valid && in_ready;
    assign sof_xfer = xfer && in_sof;
    assign busy     = (state == S_RUN);

    // A write in the same cycle as sof must be visible to that sof pixel.
    assign eff_th0 = cfg_we ? cfg_th0 : sh_th0;
    assign eff_th1 = cfg_we ? cfg_th1 : sh_th1;
    assign th_ok   = eff_th0 < eff_th1;
    assign take_th = sof_xfer && th_ok;

    assign cmp_a   = in_data;
    assign cmp_th0 = take_th ? eff_th0 : act_th0;
    assign cmp_th1 = take_th ? eff_th1 : act_th1;

    assign pos_x = in_sof ? '0 : x_cnt;
    assign pos_y = in_sof ? '0 : y_cnt;

    always_comb begin
        state_nxt   = state;
        x_nxt       = x_cnt;
        y_nxt       = y_cnt;
        restart_nxt = restart;
        fwd         = 1'b0;
        step        = 1'b0;
        err_set     = 1'b0;
        eof_hit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (sof_xfer) begin
                    fwd       = 1'b1;
                    step      = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    fwd = 1'b1;
                    if (in_sof) begin
                        // Unexpected sof: flag it, then resume the new frame after ERR.
                        state_nxt   = S_ERR;
                        err_set     = 1'b1;
                        restart_nxt = 1'b1;
                        x_nxt       = X_AFTER_SOF;
                        y_nxt       = '0;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            S_ERR: begin
                state_nxt   = restart ? S_RUN : S_IDLE;
                restart_nxt = 1'b0;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (step) begin
            if (in_eol != (pos_x == X_LAST)) begin
                state_nxt   = S_ERR;
                err_set     = 1'b1;
                restart_nxt = 1'b0;
                x_nxt       = '0;
                y_nxt       = '0;
            end else if (in_eol) begin
                x_nxt = '0;
                if (pos_y == Y_LAST) begin
                    state_nxt = S_IDLE;
                    eof_hit   = 1'b1;
                    y_nxt     = '0;
                end else begin
                    y_nxt = pos_y + 1'b1;
                end
            end else begin
                x_nxt = pos_x + 1'b1;
                y_nxt = pos_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            x_cnt     <= '0;
            y_cnt     <= '0;
            restart   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            frm_err   <= 1'b0;
            cfg_err   <= 1'b0;
            sh_th0    <= TH0_RST;
            sh_th1    <= TH1_RST;
            act_th0   <= TH0_RST;
            act_th1   <= TH1_RST;
        end else begin
            state   <= state_nxt;
            x_cnt   <= x_nxt;
            y_cnt   <= y_nxt;
            restart <= restart_nxt;
            frm_err <= err_set;
            if (fwd) begin
                out_valid <= 1'b1;
                out_data  <= cmp_out;
                out_sof   <= in_sof;
                out_eol   <= in_eol;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (cfg_we) begin
                sh_th0 <= cfg_th0;
                sh_th1 <= cfg_th1;
            end
            if (take_th) begin
                act_th0 <= eff_th0;
                act_th1 <= eff_th1;
            end
            if (sof_xfer && !th_ok)
                cfg_err <= 1'b1;
            else if (cfg_we)
                cfg_err <= 1'b0;
        end
    end

`ifdef BLEND_STATS_EN
    logic [23:0] cnt_lo, cnt_mid, cnt_hi;
    logic [23:0] lo_nxt, mid_nxt, hi_nxt;
    logic        is_lo, is_hi;

    function automatic logic [23:0] sat_inc(input logic [23:0] v, input logic inc);
        return (inc && (v != 24'hFF_FFFF)) ? v + 24'd1 : v;
    endfunction

    assign is_lo   = in_data < cmp_th0;
    assign is_hi   = in_data > cmp_th1;
    // A sof pixel always opens a fresh count, even after an aborted frame.
    assign lo_nxt  = sat_inc(in_sof ? 24'd0 : cnt_lo, is_lo);
    assign mid_nxt = sat_inc(in_sof ? 24'd0 : cnt_mid, !is_lo && !is_hi);
    assign hi_nxt  = sat_inc(in_sof ? 24'd0 : cnt_hi, is_hi);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_lo   <= '0;
            cnt_mid  <= '0;
            cnt_hi   <= '0;
            stat_lo  <= '0;
            stat_mid <= '0;
            stat_hi  <= '0;
            stat_vld <= 1'b0;
        end else begin
            stat_vld <= 1'b0;
            if (eof_hit) begin
                stat_lo  <= lo_nxt;
                stat_mid <= mid_nxt;
                stat_hi  <= hi_nxt;
                stat_vld <= 1'b1;
                cnt_lo   <= '0;
                cnt_mid  <= '0;
                cnt_hi   <= '0;
            end else if (fwd) begin
                cnt_lo  <= lo_nxt;
                cnt_mid <= mid_nxt;
                cnt_hi  <= hi_nxt;
            end
        end
    end
`endif

endmodule
